scan_req_arb: RTL and testbench

- Round-robin arbiter that shares the single mem_reg_mux scan access port between NREQ independent requesters, for example the scan-chain rwctr and an on-chip debug master.
- Serialises requests with one transaction outstanding at a time.
- Issues a one-cycle scan_wen/scan_ren strobe, waits for scan_ready, then returns read data and a done pulse to the winning requester.
- A watchdog terminates transactions that are never acknowledged, flagging an error.

---
 rtl/scan_arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 33 +++
 rtl/scan_req_arb.sv | 152 +++++++++++++++
 tb/tb_scan_req_arb.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_arb_pkg.sv
// rtl/scan_arb_pkg.sv - shared types and defaults for the scan access arbiter
package scan_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int          DEF_AW          = 14;
    localparam int          DEF_DW          = 32;
    localparam int          DEF_TIMEOUT_CYC = 255;
    localparam logic [31:0] DEF_ERR_DATA    = 32'hDEAD_BEEF;

    // Wide enough to hold TIMEOUT_CYC itself so the counter can saturate.
    function automatic int cnt_width(input int timeout_cyc);
        return $clog2(timeout_cyc + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, first set bit from ptr upward
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    logic found;
    int   j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/scan_req_arb.sv
// rtl/scan_req_arb.sv - round-robin arbiter sharing the mem_reg_mux scan port
module scan_req_arb
    import scan_arb_pkg::*;
#(
    parameter int              NREQ        = 2,
    parameter int              AW          = DEF_AW,
    parameter int              DW          = DEF_DW,
    parameter int              TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter logic [DW-1:0]   ERR_DATA    = DW'(DEF_ERR_DATA)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_wr,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_done,
    output logic               req_err,
    output logic [DW-1:0]      req_rdata,
    output logic               scan_wen,
    output logic               scan_ren,
    output logic [AW-1:0]      scan_addr,
    output logic [DW-1:0]      scan_wdata,
    input  logic [DW-1:0]      scan_rdata,
    input  logic               scan_ready,
    output logic               busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = cnt_width(TIMEOUT_CYC);

    state_e            state_q, state_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]     win_q, win_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   req_done_q, req_done_d;
    logic              req_err_q, req_err_d;
    logic [DW-1:0]     req_rdata_q, req_rdata_d;
    logic              scan_wen_q, scan_wen_d;
    logic              scan_ren_q, scan_ren_d;
    logic [AW-1:0]     scan_addr_q, scan_addr_d;
    logic [DW-1:0]     scan_wdata_q, scan_wdata_d;

    logic [NREQ-1:0]   pick_gnt;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic              pick_wr;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign pick_any = |pick_gnt;
    assign pick_wr  = |(pick_gnt & req_wr);

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        win_d        = win_q;
        cnt_d        = cnt_q;
        req_done_d   = '0;
        req_err_d    = req_err_q;
        req_rdata_d  = req_rdata_q;
        scan_wen_d   = 1'b0;
        scan_ren_d   = 1'b0;
        scan_addr_d  = scan_addr_q;
        scan_wdata_d = scan_wdata_q;

        case (state_q)
            IDLE: begin
                // scan_ready is deliberately ignored here so stray pulses vanish.
                if (pick_any) begin
                    win_d        = pick_idx;
                    scan_wen_d   = pick_wr;
                    scan_ren_d   = !pick_wr;
                    scan_addr_d  = req_addr[int'(pick_idx)*AW +: AW];
                    scan_wdata_d = req_wdata[int'(pick_idx)*DW +: DW];
                    cnt_d        = '0;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                if (scan_ready) begin
                    req_rdata_d = scan_rdata;
                    req_err_d   = 1'b0;
                    req_done_d  = NREQ'(1) << win_q;
                    state_d     = DONE;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    req_rdata_d = ERR_DATA;
                    req_err_d   = 1'b1;
                    req_done_d  = NREQ'(1) << win_q;
                    state_d     = DONE;
                end else if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                rr_ptr_d     = (int'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;
                scan_addr_d  = '0;
                scan_wdata_d = '0;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            win_q        <= '0;
            cnt_q        <= '0;
            req_done_q   <= '0;
            req_err_q    <= 1'b0;
            req_rdata_q  <= '0;
            scan_wen_q   <= 1'b0;
            scan_ren_q   <= 1'b0;
            scan_addr_q  <= '0;
            scan_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            win_q        <= win_d;
            cnt_q        <= cnt_d;
            req_done_q   <= req_done_d;
            req_err_q    <= req_err_d;
            req_rdata_q  <= req_rdata_d;
            scan_wen_q   <= scan_wen_d;
            scan_ren_q   <= scan_ren_d;
            scan_addr_q  <= scan_addr_d;
            scan_wdata_q <= scan_wdata_d;
        end
    end

    assign req_done   = req_done_q;
    assign req_err    = req_err_q;
    assign req_rdata  = req_rdata_q;
    assign scan_wen   = scan_wen_q;
    assign scan_ren   = scan_ren_q;
    assign scan_addr  = scan_addr_q;
    assign scan_wdata = scan_wdata_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_scan_req_arb.sv
// tb/tb_scan_req_arb.sv - self-checking bench for scan_req_arb with a transaction-level model
module tb_scan_req_arb;

    localparam int          NREQ = 3;
    localparam int          AW   = 14;
    localparam int          DW   = 32;
    localparam int          TO   = 10;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_wr;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_done;
    logic               req_err;
    logic [DW-1:0]      req_rdata;
    logic               scan_wen;
    logic               scan_ren;
    logic [AW-1:0]      scan_addr;
    logic [DW-1:0]      scan_wdata;
    logic [DW-1:0]      scan_rdata;
    logic               scan_ready;
    logic               busy;

    scan_req_arb #(
        .NREQ        (NREQ),
        .AW          (AW),
        .DW          (DW),
        .TIMEOUT_CYC (TO),
        .ERR_DATA    (ERRD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_done   (req_done),
        .req_err    (req_err),
        .req_rdata  (req_rdata),
        .scan_wen   (scan_wen),
        .scan_ren   (scan_ren),
        .scan_addr  (scan_addr),
        .scan_wdata (scan_wdata),
        .scan_rdata (scan_rdata),
        .scan_ready (scan_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Requester-side view of the request fields.
    logic [AW-1:0] a_addr  [NREQ];
    logic [DW-1:0] a_wdata [NREQ];
    logic          a_wr    [NREQ];
    int            model_ptr = 0;

    // Observations from the last transaction.
    logic          got_wen, got_ren, got_busy;
    logic [AW-1:0] got_addr;
    logic [DW-1:0] got_wdata;
    logic [NREQ-1:0] got_done;
    logic [DW-1:0] got_rdata;
    logic          got_err;
    int            got_lat, got_swait, got_extra;

    task automatic drive_req(input logic [NREQ-1:0] mask);
        req_valid = mask;
        for (int i = 0; i < NREQ; i++) begin
            req_wr[i]              = a_wr[i];
            req_addr[i*AW +: AW]   = a_addr[i];
            req_wdata[i*DW +: DW]  = a_wdata[i];
        end
    endtask

    function automatic int expect_winner(input logic [NREQ-1:0] m, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (m[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Waits for the strobe, plays the mux (ready after 'delay' WAIT cycles, never if
    // delay >= TO), and records what the arbiter showed. Returns at the done negedge.
    task automatic observe(input int delay, input logic [DW-1:0] rd, input bit drop);
        got_wen = 0; got_ren = 0; got_busy = 0; got_addr = '0; got_wdata = '0;
        got_done = '0; got_rdata = '0; got_err = 0; got_lat = -1; got_swait = -1; got_extra = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (scan_wen || scan_ren) begin
                got_swait = k;
                break;
            end
        end
        if (got_swait < 0) return;
        got_wen = scan_wen; got_ren = scan_ren; got_busy = busy;
        got_addr = scan_addr; got_wdata = scan_wdata;
        if (drop) req_valid = '0;
        for (int c = 0; c < TO + 5; c++) begin
            if (c == delay) begin
                scan_ready = 1'b1;
                scan_rdata = rd;
            end
            @(negedge clk);
            scan_ready = 1'b0;
            scan_rdata = $urandom;
            if (req_done != '0) begin
                got_done = req_done; got_rdata = req_rdata; got_err = req_err; got_lat = c;
                break;
            end
            got_extra += int'(scan_wen | scan_ren);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        scan_rdata = '0; scan_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if ({req_done, req_err, scan_wen, scan_ren, busy} !== '0)
            $display("FAIL reset_ctrl: got %b want 0", {req_done, req_err, scan_wen, scan_ren, busy}); else n_pass++;
        n_checks++; if ({req_rdata, scan_addr, scan_wdata} !== '0)
            $display("FAIL reset_data: got %h want 0", {req_rdata, scan_addr, scan_wdata}); else n_pass++;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if ({scan_wen, scan_ren, busy} !== 3'b000)
            $display("FAIL idle_no_strobe: got %b want 000", {scan_wen, scan_ren, busy}); else n_pass++;
        model_ptr = 0;
    endtask

    task automatic test_single_read;
        a_wr[0] = 0; a_addr[0] = 14'h0123; a_wdata[0] = 32'h0;
        drive_req(3'b001);
        observe(2, 32'hA5A5_0001, 0);
        req_valid = '0;
        n_checks++; if ({got_ren, got_wen} !== 2'b10)
            $display("FAIL rd_strobe: got ren,wen=%b want 10", {got_ren, got_wen}); else n_pass++;
        n_checks++; if (got_addr !== 14'h0123)
            $display("FAIL rd_addr: got %h want 0123", got_addr); else n_pass++;
        n_checks++; if (got_busy !== 1'b1)
            $display("FAIL rd_busy: got %b want 1", got_busy); else n_pass++;
        n_checks++; if (got_done !== 3'b001 || got_lat !== 2)
            $display("FAIL rd_done: got %b lat %0d want 001 lat 2", got_done, got_lat); else n_pass++;
        n_checks++; if (got_rdata !== 32'hA5A5_0001 || got_err !== 1'b0)
            $display("FAIL rd_data: got %h err %b want a5a50001 err 0", got_rdata, got_err); else n_pass++;
        n_checks++; if (got_extra !== 0)
            $display("FAIL rd_single_strobe: got %0d extra strobes want 0", got_extra); else n_pass++;
        model_ptr = 1;
    endtask

    task automatic test_single_write;
        @(negedge clk);
        a_wr[1] = 1; a_addr[1] = 14'h3FFF; a_wdata[1] = 32'h1234_5678;
        drive_req(3'b010);
        observe(0, 32'h0BAD_F00D, 0);
        req_valid = '0;
        n_checks++; if ({got_wen, got_ren} !== 2'b10 || got_swait !== 1)
            $display("FAIL wr_strobe: got wen,ren=%b at %0d want 10 at 1", {got_wen, got_ren}, got_swait); else n_pass++;
        n_checks++; if (got_addr !== 14'h3FFF || got_wdata !== 32'h1234_5678)
            $display("FAIL wr_addr_data: got %h/%h want 3fff/12345678", got_addr, got_wdata); else n_pass++;
        n_checks++; if (got_done !== 3'b010 || got_lat !== 0 || got_err !== 1'b0)
            $display("FAIL wr_done: got %b lat %0d err %b want 010 lat 0 err 0", got_done, got_lat, got_err); else n_pass++;
        model_ptr = 2;
    endtask

    task automatic test_round_robin;
        int exp_w;
        a_wr[0] = 0; a_wr[1] = 1;
        drive_req(3'b011);
        for (int t = 0; t < 6; t++) begin
            exp_w = t % 2;
            observe(int'($urandom_range(0, 3)), $urandom, 0);
            n_checks++; if (got_done !== (3'b001 << exp_w) || !$onehot(got_done))
                $display("FAIL rr_grant%0d: got %b want %b", t, got_done, 3'b001 << exp_w); else n_pass++;
            n_checks++; if (got_addr !== a_addr[exp_w] || got_wen !== a_wr[exp_w])
                $display("FAIL rr_fields%0d: got %h/%b want %h/%b", t, got_addr, got_wen, a_addr[exp_w], a_wr[exp_w]); else n_pass++;
            model_ptr = (exp_w + 1) % NREQ;
        end
        req_valid = '0;
    endtask

    task automatic test_timeout;
        @(negedge clk);
        a_wr[2] = 0; a_addr[2] = 14'h2222;
        drive_req(3'b100);
        observe(TO + 3, 32'h0, 0);
        req_valid = '0;
        n_checks++; if (got_done !== 3'b100 || got_err !== 1'b1 || got_rdata !== ERRD)
            $display("FAIL to_done: got %b err %b data %h want 100 err 1 data deadbeef", got_done, got_err, got_rdata); else n_pass++;
        n_checks++; if (got_lat !== TO - 1)
            $display("FAIL to_len: got %0d wait cycles want %0d", got_lat + 1, TO); else n_pass++;
        model_ptr = 0;
        @(negedge clk);
        a_wr[0] = 0; a_addr[0] = 14'h0042;
        drive_req(3'b001);
        observe(1, 32'h5555_AAAA, 0);
        req_valid = '0;
        n_checks++; if (got_done !== 3'b001 || got_err !== 1'b0 || got_rdata !== 32'h5555_AAAA)
            $display("FAIL to_recover: got %b err %b data %h want 001 err 0 data 5555aaaa", got_done, got_err, got_rdata); else n_pass++;
        model_ptr = 1;
    endtask

    task automatic test_collision;
        int stray_done;
        @(negedge clk);
        a_wr[1] = 0; a_addr[1] = 14'h1111;
        drive_req(3'b010);
        observe(TO - 1, 32'hC011_1DE0, 0);
        req_valid = '0;
        n_checks++; if (got_done !== 3'b010 || got_err !== 1'b0 || got_rdata !== 32'hC011_1DE0 || got_lat !== TO - 1)
            $display("FAIL collide: got %b err %b data %h lat %0d want 010 err 0 data c0111de0 lat %0d",
                     got_done, got_err, got_rdata, got_lat, TO - 1); else n_pass++;
        model_ptr = 2;
        repeat (2) @(negedge clk);
        stray_done = 0;
        for (int k = 0; k < 5; k++) begin
            scan_ready = 1'b1; scan_rdata = $urandom;
            @(negedge clk);
            scan_ready = 1'b0;
            @(negedge clk);
            if (req_done != '0 || busy || scan_wen || scan_ren) stray_done++;
        end
        n_checks++; if (stray_done !== 0)
            $display("FAIL stray_ready: got %0d reacting cycles want 0", stray_done); else n_pass++;
        n_checks++; if (req_rdata !== 32'hC011_1DE0 || req_err !== 1'b0)
            $display("FAIL rdata_hold: got %h err %b want c0111de0 err 0", req_rdata, req_err); else n_pass++;
    endtask

    task automatic test_reset_mid_wait;
        bit seen;
        a_wr[1] = 1; a_addr[1] = 14'h0777; a_wdata[1] = 32'h7777_7777;
        a_wr[2] = 0; a_addr[2] = 14'h0888;
        drive_req(3'b110);
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (scan_wen || scan_ren) begin seen = 1; break; end
        end
        n_checks++; if (!seen || scan_addr !== 14'h0888)
            $display("FAIL rst_pre_pick: got seen %b addr %h want 1 0888", seen, scan_addr); else n_pass++;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if ({req_done, req_err, scan_wen, scan_ren, busy, req_rdata, scan_addr, scan_wdata} !== '0)
            $display("FAIL rst_async: got busy %b addr %h rdata %h want all 0", busy, scan_addr, req_rdata); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
        observe(0, 32'h1357_9BDF, 0);
        req_valid = '0;
        n_checks++; if (got_swait !== 1 || got_done !== 3'b010 || got_wen !== 1'b1 || got_addr !== 14'h0777)
            $display("FAIL rst_restart: got wait %0d done %b wen %b addr %h want 1 010 1 0777",
                     got_swait, got_done, got_wen, got_addr); else n_pass++;
        model_ptr = 2;
    endtask

    task automatic test_random;
        logic [NREQ-1:0] mask;
        logic [DW-1:0]   rd;
        int              w, dly, errs;
        bit              drop;
        errs = 0;
        @(negedge clk);
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                a_wr[i] = 1'($urandom); a_addr[i] = AW'($urandom); a_wdata[i] = $urandom;
            end
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            drive_req(mask);
            w    = expect_winner(mask, model_ptr);
            dly  = int'($urandom_range(0, TO + 1));
            rd   = $urandom;
            drop = ($urandom_range(0, 3) == 0);
            observe(dly, rd, drop);
            if (got_done !== (3'b001 << w) || got_wen !== a_wr[w] || got_ren !== !a_wr[w] ||
                got_addr !== a_addr[w] || got_wdata !== a_wdata[w] ||
                got_err !== (dly >= TO) || got_rdata !== ((dly >= TO) ? ERRD : rd) ||
                got_lat !== ((dly >= TO) ? TO - 1 : dly) || got_extra !== 0) begin
                errs++;
                $display("FAIL rand%0d: got done %b addr %h err %b data %h lat %0d want done %b addr %h err %b",
                         t, got_done, got_addr, got_err, got_rdata, got_lat, 3'b001 << w, a_addr[w], dly >= TO);
            end
            model_ptr = (w + 1) % NREQ;
            if ($urandom_range(0, 1) == 0) req_valid = '0;
        end
        req_valid = '0;
        n_checks++; if (errs !== 0)
            $display("FAIL random_txns: got %0d bad transactions want 0", errs); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            a_addr[i] = '0; a_wdata[i] = '0; a_wr[i] = 1'b0;
        end
        test_reset;
        test_single_read;
        test_single_write;
        test_round_robin;
        test_timeout;
        test_collision;
        test_reset_mid_wait;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
